// File: rtl/stat_reg_table_pkg.sv
// Shared constants and types for the statistics register table.
// Well-known counter addresses are listed here so initiators and management software agree.
package stat_reg_pkg;
    localparam int AW    = 7;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } chan_state_e;

    localparam logic [AW-1:0] ADDR_RX_FLOW = 7'h10;
    localparam logic [AW-1:0] ADDR_TX_FLOW = 7'h11;
    localparam logic [AW-1:0] ADDR_ERR_CRC = 7'h12;
endpackage

// File: rtl/stat_reg_table_if.sv
// Statistics write bus (NPORT initiators) plus the management read port.
// The master side is the initiators/management agent; the slave side is the register table.
interface stat_reg_table_if #(parameter int NPORT = 2) ();
    import stat_reg_pkg::*;

    logic [NPORT*AW-1:0] port_addr;
    logic [NPORT*DW-1:0] port_din;
    logic [NPORT-1:0]    port_req;
    logic [NPORT-1:0]    port_ack;
    logic                mgmt_rd;
    logic [AW-1:0]       mgmt_addr;
    logic [DW-1:0]       mgmt_rdata;
    logic                mgmt_rvalid;
    logic                mgmt_fresh;

    modport master (
        output port_addr, port_din, port_req, mgmt_rd, mgmt_addr,
        input  port_ack, mgmt_rdata, mgmt_rvalid, mgmt_fresh
    );

    modport slave (
        input  port_addr, port_din, port_req, mgmt_rd, mgmt_addr,
        output port_ack, mgmt_rdata, mgmt_rvalid, mgmt_fresh
    );
endinterface

// File: rtl/stat_reg_table_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the channel after the last winner.
module rr_arbiter #(
    parameter int NPORT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NPORT-1:0] req_i,
    output logic [NPORT-1:0] gnt_o
);
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Scan from the farthest offset back to the pointer so the nearest requester is assigned last.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        for (int k = NPORT - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr_q) + k) % NPORT;
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                ptr_d      = PW'((idx + 1) % NPORT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/stat_reg_table.sv
// Register-table responder: arbitrates initiator writes into a 128x16 flop file with
// per-entry fresh bits, and serves registered management reads.
//   state    | meaning
//   IDLE     | channel may be granted when its req is high
//   WAIT_LOW | acked; waits for req sampled low so a held req is not written twice
module stat_reg_table
    import stat_reg_pkg::*;
#(
    parameter int NPORT = 2
) (
    input logic               clk,
    input logic               rst_n,
    stat_reg_table_if.slave   bus
);
    chan_state_e      state_q [NPORT];
    chan_state_e      state_d [NPORT];
    logic [NPORT-1:0] elig;
    logic [NPORT-1:0] gnt;
    logic [NPORT-1:0] ack_q;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] fresh_q;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;

    logic [DW-1:0]    rdata_q;
    logic             rvalid_q;
    logic             rfresh_q;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NPORT; i++) begin
            elig[i] = (state_q[i] == IDLE) && bus.port_req[i];
        end
    end

    rr_arbiter #(.NPORT(NPORT)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (elig),
        .gnt_o (gnt)
    );

    always_comb begin
        waddr = '0;
        wdata = '0;
        for (int i = 0; i < NPORT; i++) begin
            state_d[i] = state_q[i];
            if (gnt[i]) begin
                state_d[i] = WAIT_LOW;
                waddr      = bus.port_addr[i*AW +: AW];
                wdata      = bus.port_din[i*DW +: DW];
            end else if (state_q[i] == WAIT_LOW && !bus.port_req[i]) begin
                state_d[i] = IDLE;
            end
        end
    end

    // The write's fresh update follows the read's clear so a same-edge write leaves fresh set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NPORT; i++) begin
                state_q[i] <= IDLE;
            end
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= '0;
            end
            fresh_q  <= '0;
            ack_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rfresh_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= gnt;
            rvalid_q <= bus.mgmt_rd;
            if (bus.mgmt_rd) begin
                rdata_q                 <= mem_q[bus.mgmt_addr];
                rfresh_q                <= fresh_q[bus.mgmt_addr];
                fresh_q[bus.mgmt_addr]  <= 1'b0;
            end
            if (|gnt) begin
                mem_q[waddr]   <= wdata;
                fresh_q[waddr] <= 1'b1;
            end
        end
    end

    assign bus.port_ack    = ack_q;
    assign bus.mgmt_rdata  = rdata_q;
    assign bus.mgmt_rvalid = rvalid_q;
    assign bus.mgmt_fresh  = rfresh_q;
endmodule
